alu_decode_stage: RTL
=====================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 i_clk  input  1  Single clock; all state updates on rising edge.
REQ-002 i_rst_n  input  1  Reset, synchronous, active-low.
REQ-003 i_flush  input  1  Discard the held and incoming instruction.
REQ-004 i_instr_vld  input  1  Upstream instruction valid.
REQ-005 i_instr  input  32  RV32I instruction word.
REQ-006 i_pc  input  32  PC of i_instr.
REQ-007 o_instr_rdy  output  1  Stage can accept; combinational, = ~o_vld | i_rdy.
REQ-008 i_rdy  input  1  Downstream (ALU/execute) accepts the held entry.
REQ-009 o_vld  output  1  Registered decode result valid.
REQ-010 o_alu_op  output  4  ALU op: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 pass operand B.
REQ-011 o_opa_sel  output  1  Operand A source: 0 = rs1, 1 = PC.
REQ-012 o_opb_sel  output  1  Operand B source: 0 = rs2, 1 = o_imm.
REQ-013 o_imm  output  32  Sign-extended immediate; 0 for R-type.
REQ-014 o_rs1_addr, o_rs2_addr, o_rd_addr  output  5 each  Register fields instr[19:15], [24:20], [11:7].
REQ-015 o_rd_wren  output  1  Register write enable.
REQ-016 o_pc  output  32  Registered PC.
REQ-017 o_illegal  output  1  Instruction not in the supported set.

Function
REQ-018 Transfer in when i_instr_vld & o_instr_rdy & ~i_flush; all outputs register the decode of i_instr/i_pc on that edge; o_vld <= 1; latency 1 cycle.
REQ-019 If o_vld & i_rdy and no transfer in, o_vld <= 0; simultaneous drain and transfer in keeps o_vld = 1 with the new entry.
REQ-020 If o_vld & ~i_rdy, every output holds its value and o_instr_rdy = 0.
REQ-021 i_flush = 1: o_vld <= 0 next edge; the same-cycle incoming instruction is dropped; flush beats transfer and drain.
REQ-022 OP (0110011): funct7 0000000 selects funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND; funct7 0100000 with funct3 000 gives SUB and with 101 gives SRA; other funct7 is illegal; opb_sel 0.
REQ-023 OP-IMM (0010011): same funct3 map with I-immediate and opb_sel 1; funct3 000 is always ADD; funct3 001 requires imm[11:5]=0000000; funct3 101 uses imm[11:5] 0000000 = SRL and 0100000 = SRA; other imm[11:5] with 001/101 is illegal.
REQ-024 LUI: op 1010, opb_sel 1, imm = {instr[31:12],12'b0}.
REQ-025 AUIPC: ADD, opa_sel 1, opb_sel 1, U-immediate.
REQ-026 JAL: ADD, opa_sel 1, J-immediate. JALR (funct3 000 only): ADD, rs1 + I-immediate.
REQ-027 BRANCH: ADD, opa_sel 1, B-immediate, rd_wren 0; funct3 010/011 illegal.
REQ-028 LOAD (funct3 000, 001, 010, 100, 101): ADD, rs1 + I-immediate. STORE (funct3 000, 001, 010): ADD, S-immediate, rd_wren 0.
REQ-029 Any other opcode or funct is illegal: o_illegal 1, o_alu_op 0000, o_rd_wren 0, o_vld still asserted.
REQ-030 o_rd_wren is forced to 0 whenever rd = 0.

Reset
REQ-031 i_rst_n = 0 at an edge clears o_vld and every registered output to 0, regardless of flush or handshake.
REQ-032 While i_rst_n = 0, o_instr_rdy = 1 because o_vld = 0; no transfer occurs.

Verification
REQ-033 Instr 0x002081B3 (add x3,x1,x2) with i_rdy=1 -> next cycle o_vld=1, op 0000, rs1=1, rs2=2, rd=3, opb_sel 0, rd_wren 1.
REQ-034 Instr 0x40335293 (srai x5,x6,3) -> op 0111, o_imm 0x00000403, opb_sel 1, rd=5.
REQ-035 Instr 0xABCDE0B7 (lui x1) -> op 1010, o_imm 0xABCDE000, opb_sel 1.
REQ-036 Hold i_rdy=0 for 3 cycles with a new instruction pending -> o_instr_rdy=0 and outputs stable; raise i_rdy -> the pending instruction is loaded on the next edge.
REQ-037 Instr 0xFFFFFFFF -> o_illegal 1, rd_wren 0; flush in the same cycle as a transfer -> o_vld 0 next cycle.
REQ-038 Drive reset low while o_vld=1 and i_rdy=0 -> all outputs 0 next edge.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: one-entry registered decode buffer with valid/ready handshake.
// Produces ALU op, operand selects, immediate, register fields and an illegal flag.
module alu_decode_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_instr_vld,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_instr_rdy,
  input  logic        i_rdy,
  output logic        o_vld,
  output logic [3:0]  o_alu_op,
  output logic        o_opa_sel,
  output logic        o_opb_sel,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren,
  output logic [31:0] o_pc,
  output logic        o_illegal
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  localparam logic [6:0] Funct7Zero = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluSll  = 4'b0010;
  localparam logic [3:0] AluSlt  = 4'b0011;
  localparam logic [3:0] AluSltu = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluOr   = 4'b1000;
  localparam logic [3:0] AluAnd  = 4'b1001;
  localparam logic [3:0] AluPassB = 4'b1010;

  // Shared funct3 map for OP and OP-IMM; i_alt picks SUB/SRA.
  function automatic logic [3:0] f3_to_op(input logic [2:0] i_f3, input logic i_alt);
    logic [3:0] op;
    case (i_f3)
      3'b000:  op = i_alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = i_alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_rd     = i_instr[11:7];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  logic [3:0]  w_alu_op;
  logic        w_opa_sel;
  logic        w_opb_sel;
  logic [31:0] w_imm;
  logic        w_rd_wren;
  logic        w_illegal;

  always_comb begin
    w_alu_op  = AluAdd;
    w_opa_sel = 1'b0;
    w_opb_sel = 1'b0;
    w_imm     = '0;
    w_rd_wren = 1'b0;
    w_illegal = 1'b0;

    case (w_opcode)
      OpcOp: begin
        w_rd_wren = 1'b1;
        if (w_funct7 == Funct7Zero) begin
          w_alu_op = f3_to_op(w_funct3, 1'b0);
        end else if (w_funct7 == Funct7Alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
          w_alu_op = f3_to_op(w_funct3, 1'b1);
        end else begin
          w_illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        w_opb_sel = 1'b1;
        w_imm     = w_imm_i;
        w_rd_wren = 1'b1;
        // Only the shift forms constrain imm[11:5]; ADDI never means SUB.
        case (w_funct3)
          3'b001: begin
            w_alu_op  = AluSll;
            w_illegal = (w_funct7 != Funct7Zero);
          end
          3'b101: begin
            if (w_funct7 == Funct7Zero) begin
              w_alu_op = AluSrl;
            end else if (w_funct7 == Funct7Alt) begin
              w_alu_op = AluSra;
            end else begin
              w_illegal = 1'b1;
            end
          end
          default: w_alu_op = f3_to_op(w_funct3, 1'b0);
        endcase
      end
      OpcLui: begin
        w_alu_op  = AluPassB;
        w_opb_sel = 1'b1;
        w_imm     = w_imm_u;
        w_rd_wren = 1'b1;
      end
      OpcAuipc: begin
        w_opa_sel = 1'b1;
        w_opb_sel = 1'b1;
        w_imm     = w_imm_u;
        w_rd_wren = 1'b1;
      end
      OpcJal: begin
        w_opa_sel = 1'b1;
        w_opb_sel = 1'b1;
        w_imm     = w_imm_j;
        w_rd_wren = 1'b1;
      end
      OpcJalr: begin
        w_opb_sel = 1'b1;
        w_imm     = w_imm_i;
        w_rd_wren = 1'b1;
        w_illegal = (w_funct3 != 3'b000);
      end
      OpcBranch: begin
        w_opa_sel = 1'b1;
        w_opb_sel = 1'b1;
        w_imm     = w_imm_b;
        w_illegal = (w_funct3 == 3'b010 || w_funct3 == 3'b011);
      end
      OpcLoad: begin
        w_opb_sel = 1'b1;
        w_imm     = w_imm_i;
        w_rd_wren = 1'b1;
        w_illegal = (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111);
      end
      OpcStore: begin
        w_opb_sel = 1'b1;
        w_imm     = w_imm_s;
        w_illegal = (w_funct3[2] || w_funct3 == 3'b011);
      end
      default: w_illegal = 1'b1;
    endcase

    // Illegal entries carry a neutral payload so execute never acts on them.
    if (w_illegal) begin
      w_alu_op  = AluAdd;
      w_opa_sel = 1'b0;
      w_opb_sel = 1'b0;
      w_imm     = '0;
      w_rd_wren = 1'b0;
    end

    if (w_rd == 5'd0) begin
      w_rd_wren = 1'b0;
    end
  end

  logic        r_vld;
  logic [3:0]  r_alu_op;
  logic        r_opa_sel;
  logic        r_opb_sel;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;
  logic [4:0]  r_rd_addr;
  logic        r_rd_wren;
  logic [31:0] r_pc;
  logic        r_illegal;

  logic w_instr_rdy;
  logic w_xfer;

  assign w_instr_rdy = ~r_vld | i_rdy;
  assign w_xfer      = i_instr_vld & w_instr_rdy & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld      <= 1'b0;
      r_alu_op   <= '0;
      r_opa_sel  <= 1'b0;
      r_opb_sel  <= 1'b0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_rd_wren  <= 1'b0;
      r_pc       <= '0;
      r_illegal  <= 1'b0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (w_xfer) begin
      r_vld      <= 1'b1;
      r_alu_op   <= w_alu_op;
      r_opa_sel  <= w_opa_sel;
      r_opb_sel  <= w_opb_sel;
      r_imm      <= w_imm;
      r_rs1_addr <= i_instr[19:15];
      r_rs2_addr <= i_instr[24:20];
      r_rd_addr  <= w_rd;
      r_rd_wren  <= w_rd_wren;
      r_pc       <= i_pc;
      r_illegal  <= w_illegal;
    end else if (r_vld && i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_instr_rdy = w_instr_rdy;
  assign o_vld       = r_vld;
  assign o_alu_op    = r_alu_op;
  assign o_opa_sel   = r_opa_sel;
  assign o_opb_sel   = r_opb_sel;
  assign o_imm       = r_imm;
  assign o_rs1_addr  = r_rs1_addr;
  assign o_rs2_addr  = r_rs2_addr;
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_wren   = r_rd_wren;
  assign o_pc        = r_pc;
  assign o_illegal   = r_illegal;

endmodule
